// File: rtl/md_pkg.sv
// Shared widths and types for the force-accumulation network.
package md_pkg;
   localparam int NODE_ID_WIDTH     = 6;
   localparam int PARTICLE_ID_WIDTH = 7;
   localparam int NUM_PARTICLES     = 128;
   localparam int DATA_WIDTH        = 32;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data_x;
      logic [DATA_WIDTH-1:0] data_y;
      logic [DATA_WIDTH-1:0] data_z;
   } data_tuple_t;

   typedef struct packed {
      logic [NODE_ID_WIDTH-1:0]     dest_id;
      logic [PARTICLE_ID_WIDTH-1:0] particle_id;
      data_tuple_t                  force_val;
   } packet_t;
endpackage

// File: rtl/force_packet_receiver_if.sv
// Packet-in handshake and accumulator readout bundle for force_packet_receiver.
interface force_packet_receiver_if;
   import md_pkg::*;

   packet_t                      pkt_in;
   logic                         pkt_valid;
   logic                         pkt_ready;
   logic                         rd_en;
   logic [PARTICLE_ID_WIDTH-1:0] rd_addr;
   data_tuple_t                  rd_data;
   logic                         rd_valid;

   modport master (output pkt_in, pkt_valid, rd_en, rd_addr,
                   input  pkt_ready, rd_data, rd_valid);
   modport slave  (input  pkt_in, pkt_valid, rd_en, rd_addr,
                   output pkt_ready, rd_data, rd_valid);
endinterface

// File: rtl/force_packet_receiver.sv
// Per-particle force accumulator: read-add-write pipeline, readout port,
// misroute counter and a sequential clear walk (also run after reset).
module force_packet_receiver
   import md_pkg::*;
#(
   parameter logic [NODE_ID_WIDTH-1:0] LOCAL_NODE_ID = '0,
   parameter int                       CNT_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   force_packet_receiver_if.slave       bus,
   input  logic                         clear_start,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         misroute_cnt
);

   typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

   state_t                       state_q, state_d;
   logic [PARTICLE_ID_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                         s1_valid_q, s1_valid_d;
   logic [PARTICLE_ID_WIDTH-1:0] s1_pid_q, s1_pid_d;
   data_tuple_t                  s1_force_q, s1_force_d;
   data_tuple_t                  rdata_q, rdata_d;
   logic                         rd_valid_q, rd_valid_d;
   logic [CNT_WIDTH-1:0]         misroute_q, misroute_d;

   data_tuple_t                  mem [NUM_PARTICLES];
   logic                         xfer, local_hit, raw_hit;
   logic [PARTICLE_ID_WIDTH-1:0] raddr, waddr;
   logic                         we;
   data_tuple_t                  wdata, s1_sum;

   assign busy      = (state_q == ST_CLEAR);
   assign local_hit = (bus.pkt_in.dest_id == LOCAL_NODE_ID);
   // Entry in S1 is not yet written back; a same-pid read now would be stale.
   assign raw_hit   = s1_valid_q && (s1_pid_q == bus.pkt_in.particle_id);
   assign bus.pkt_ready = !busy && !bus.rd_en && !raw_hit;
   assign xfer      = bus.pkt_valid && bus.pkt_ready;
   assign raddr     = bus.rd_en ? bus.rd_addr : bus.pkt_in.particle_id;

   assign s1_sum.data_x = rdata_q.data_x + s1_force_q.data_x;
   assign s1_sum.data_y = rdata_q.data_y + s1_force_q.data_y;
   assign s1_sum.data_z = rdata_q.data_z + s1_force_q.data_z;

   assign bus.rd_data  = rdata_q;
   assign bus.rd_valid = rd_valid_q;
   assign misroute_cnt = misroute_q;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      we         = 1'b0;
      waddr      = s1_pid_q;
      wdata      = s1_sum;
      case (state_q)
         ST_IDLE: begin
            if (clear_start) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            // The walk yields the write port to an in-flight S1 update.
            if (!s1_valid_q) begin
               we         = 1'b1;
               waddr      = clr_addr_q;
               wdata      = '0;
               clr_addr_d = clr_addr_q + 1'b1;
               if (clr_addr_q == PARTICLE_ID_WIDTH'(NUM_PARTICLES - 1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      if (s1_valid_q) we = 1'b1;
   end

   always_comb begin
      s1_valid_d = xfer && local_hit;
      s1_pid_d   = bus.pkt_in.particle_id;
      s1_force_d = bus.pkt_in.force_val;
      rd_valid_d = bus.rd_en && !busy;
      rdata_d    = rdata_q;
      if (rd_valid_d || xfer) rdata_d = mem[raddr];
      misroute_d = misroute_q;
      if (xfer && !local_hit && (misroute_q != {CNT_WIDTH{1'b1}}))
         misroute_d = misroute_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         s1_valid_q <= 1'b0;
         s1_pid_q   <= '0;
         s1_force_q <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         misroute_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         s1_valid_q <= s1_valid_d;
         s1_pid_q   <= s1_pid_d;
         s1_force_q <= s1_force_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
         misroute_q <= misroute_d;
      end
   end

   // Storage is not reset; the post-reset clear walk zeroes it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

endmodule

// File: tb/tb_force_packet_receiver.sv
// Bench for force_packet_receiver: readout scoreboard, vector table and
// hand-written sequences for stalls, clear and reset corner cases.
module tb_force_packet_receiver;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_start = 1'b0;
   logic        busy;
   logic [15:0] misroute_cnt;

   force_packet_receiver_if bus ();

   force_packet_receiver #(.LOCAL_NODE_ID(6'd0), .CNT_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .clear_start  (clear_start),
      .busy         (busy),
      .misroute_cnt (misroute_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      data_tuple_t  d;
      logic [6:0]   a;
   } sb_t;

   typedef struct {
      logic [5:0]  dest;
      logic [6:0]  pid;
      logic [31:0] x, y, z;
      logic [31:0] ex, ey, ez;
      logic [15:0] emis;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   sb_t  sb[$];
   sb_t  mon_e;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic data_tuple_t mk_t(input logic [31:0] x, y, z);
      data_tuple_t t;
      t.data_x = x; t.data_y = y; t.data_z = z;
      return t;
   endfunction

   function automatic packet_t mk(input logic [5:0] dest, input logic [6:0] pid,
                                  input logic [31:0] x, y, z);
      packet_t p;
      p.dest_id = dest; p.particle_id = pid; p.force_val = mk_t(x, y, z);
      return p;
   endfunction

   // Every rd_valid must match the oldest outstanding expected readout.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got rd_valid=1 with data %h expected no readout", bus.rd_data);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("rd_data[%0d]", mon_e.a), bus.rd_data, mon_e.d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input packet_t p);
      int w;
      bus.pkt_in    = p;
      bus.pkt_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.pkt_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      chk("send_ready", bus.pkt_ready, 1'b1);
      tick();
      bus.pkt_valid = 1'b0;
   endtask

   task automatic rd(input logic [6:0] a, input data_tuple_t e);
      sb_t s;
      s.d = e; s.a = a;
      sb.push_back(s);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      tick();
      bus.rd_en   = 1'b0;
   endtask

   task automatic drain();
      idle(3);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic wait_busy_low(output int n);
      int bad;
      n = 0; bad = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         n++;
         if (bus.pkt_ready) bad++;
         @(negedge clk);
      end
      chk("busy_timeout", busy, 1'b0);
      chk("ready_while_busy", bad, 0);
      chk("ready_after_busy", bus.pkt_ready, 1'b1);
      tick();
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, i, stalls, cyc, xfers, drops;
      logic r2, r3;
      packet_t acc[3];

      bus.pkt_valid = 1'b0;
      bus.pkt_in    = '0;
      bus.rd_en     = 1'b0;
      bus.rd_addr   = '0;

      tbl[0] = '{6'd0, 7'd9,   32'h7FFFFFFF, 32'h10, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h10, 32'hFFFFFFFF, 16'd0};
      tbl[1] = '{6'd0, 7'd9,   32'h1,        32'h5,  32'h1,        32'h80000000, 32'h15, 32'h0,        16'd0};
      tbl[2] = '{6'd0, 7'd20,  32'hAAAA,     32'h0,  32'hFFFFFFFE, 32'hAAAA,     32'h0,  32'hFFFFFFFE, 16'd0};
      tbl[3] = '{6'd0, 7'd20,  32'hFFFF5556, 32'h3,  32'h3,        32'h0,        32'h3,  32'h1,        16'd0};
      tbl[4] = '{6'd1, 7'd9,   32'h123,      32'h1,  32'h1,        32'h80000000, 32'h15, 32'h0,        16'd1};
      tbl[5] = '{6'd1, 7'd20,  32'h5,        32'h5,  32'h5,        32'h0,        32'h3,  32'h1,        16'd2};
      tbl[6] = '{6'd1, 7'd127, 32'h7,        32'h8,  32'h9,        32'h0,        32'h0,  32'h0,        16'd3};
      tbl[7] = '{6'd0, 7'd127, 32'h7,        32'h8,  32'h9,        32'h7,        32'h8,  32'h9,        16'd3};

      // Reset values, then the automatic post-reset walk.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pkt_ready", bus.pkt_ready, 1'b0);
      chk("rst_rd_valid", bus.rd_valid, 1'b0);
      chk("rst_rd_data", bus.rd_data, '0);
      chk("rst_misroute", misroute_cnt, 16'd0);
      chk("rst_busy", busy, 1'b1);
      tick();
      rst = 1'b0;
      wait_busy_low(n);
      chk("reset_busy_cycles", n, 128);
      rd(7'd0, '0); rd(7'd64, '0); rd(7'd127, '0);
      drain();

      // Three same-pid packets held valid back to back.
      acc[0] = mk(6'd0, 7'd5, 32'h1, 32'h0, 32'h0);
      acc[1] = mk(6'd0, 7'd5, 32'h2, 32'h0, 32'h0);
      acc[2] = mk(6'd0, 7'd5, 32'hFFFFFFFF, 32'h0, 32'h0);
      i = 0; stalls = 0; cyc = 0;
      bus.pkt_valid = 1'b1;
      while (i < 3 && cyc < 50) begin
         bus.pkt_in = acc[i];
         @(negedge clk);
         if (bus.pkt_ready) i++;
         else stalls++;
         cyc++;
         tick();
      end
      bus.pkt_valid = 1'b0;
      chk("accum_xfers", i, 3);
      chk("raw_stalls", stalls, 2);
      idle(2);
      rd(7'd5, mk_t(32'h2, 32'h0, 32'h0));
      drain();

      for (int k = 0; k < 8; k++) begin
         send(mk(tbl[k].dest, tbl[k].pid, tbl[k].x, tbl[k].y, tbl[k].z));
         idle(2);
         rd(tbl[k].pid, mk_t(tbl[k].ex, tbl[k].ey, tbl[k].ez));
         idle(2);
         chk($sformatf("tbl_misroute[%0d]", k), misroute_cnt, tbl[k].emis);
      end
      drain();

      // Readout in the same cycle as the S1 write returns the old value.
      send(mk(6'd0, 7'd30, 32'd100, 32'h0, 32'h0));
      rd(7'd30, '0);
      idle(2);
      rd(7'd30, mk_t(32'd100, 32'h0, 32'h0));
      drain();

      // clear_start coincident with a transfer, during traffic.
      r2 = 1'b0; r3 = 1'b1;
      bus.pkt_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.pkt_in  = mk(6'd0, 7'(50 + k), 32'h1, 32'h1, 32'h1);
         clear_start = (k == 2);
         @(negedge clk);
         if (k == 2) r2 = bus.pkt_ready;
         if (k == 3) r3 = bus.pkt_ready;
         tick();
      end
      bus.pkt_valid = 1'b0;
      clear_start   = 1'b0;
      chk("clear_xfer_ready", r2, 1'b1);
      chk("clear_ready_drop", r3, 1'b0);
      wait_busy_low(n);
      rd(7'd50, '0); rd(7'd52, '0); rd(7'd5, '0); rd(7'd9, '0); rd(7'd127, '0);
      drain();
      chk("clear_keeps_misroute", misroute_cnt, 16'd3);

      // A second clear_start during the walk must not restart it.
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         n++;
         if (n == 50) begin
            tick();
            clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
            n++;
         end
         @(negedge clk);
      end
      chk("clear_ignore_busy", n, 128);
      tick();

      // Full-rate stream to every pid.
      xfers = 0; drops = 0;
      bus.pkt_valid = 1'b1;
      for (int k = 0; k < 128; k++) begin
         bus.pkt_in = mk(6'd0, 7'(k), 32'(k * 3 + 1), ~32'(k), 32'(k) << 20);
         @(negedge clk);
         if (bus.pkt_ready) xfers++;
         else drops++;
         tick();
      end
      bus.pkt_valid = 1'b0;
      chk("tp_xfers", xfers, 128);
      chk("tp_ready_drops", drops, 0);
      idle(2);
      for (int k = 0; k < 128; k++)
         rd(7'(k), mk_t(32'(k * 3 + 1), ~32'(k), 32'(k) << 20));
      drain();

      // Misroute saturation.
      bus.pkt_in    = mk(6'd1, 7'd0, 32'hDEADBEEF, 32'h1, 32'h2);
      bus.pkt_valid = 1'b1;
      repeat (65532) tick();
      bus.pkt_valid = 1'b0;
      idle(1);
      chk("misroute_full", misroute_cnt, 16'hFFFF);
      send(mk(6'd1, 7'd0, 32'h1, 32'h1, 32'h1));
      idle(1);
      chk("misroute_sat", misroute_cnt, 16'hFFFF);
      idle(1);
      rd(7'd0, mk_t(32'h1, 32'hFFFFFFFF, 32'h0));
      drain();

      // Reset while a local packet sits in S1.
      send(mk(6'd0, 7'd40, 32'd55, 32'h0, 32'h0));
      rst = 1'b1;
      @(negedge clk);
      chk("rst_s1_misroute", misroute_cnt, 16'd0);
      chk("rst_s1_busy", busy, 1'b1);
      chk("rst_s1_ready", bus.pkt_ready, 1'b0);
      chk("rst_s1_rd_data", bus.rd_data, '0);
      tick();
      rst = 1'b0;
      wait_busy_low(n);
      chk("rst_s1_busy_cycles", n, 128);
      rd(7'd40, '0); rd(7'd1, '0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
